// File: rtl/pixel_stream_source.sv
// Raster-order pixel source: reads one frame from synchronous memory and
// streams it with line/frame markers under valid/ready flow control.
module pixel_stream_source #(
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned IMG_H    = 64,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned LINE_GAP = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        p_data,
  output logic              valid,
  input  logic              ready_in,
  output logic              sol,
  output logic              eol,
  output logic              sof,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned GW = 8;
  localparam int unsigned TW = 4;
  localparam int unsigned PW = 8 + TW;

  // Pixel word layout: {sof, eof, sol, eol, data[7:0]}
  localparam int unsigned B_EOL = 8;
  localparam int unsigned B_SOL = 9;
  localparam int unsigned B_EOF = 10;
  localparam int unsigned B_SOF = 11;

  localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(LINE_GAP - 1);

  typedef enum logic [1:0] {IDLE, READ, GAP, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [GW-1:0]   gap_q;
  logic [TW-1:0]   rd_tag;
  logic            pend;
  logic [TW-1:0]   pend_tag;
  logic [PW-1:0]   out_q;
  logic            out_valid;
  logic [PW-1:0]   skid0, skid1;
  logic [1:0]      skid_cnt;

  logic            issue_c, done_set_c, pop_c, x_last_c, y_last_c;
  logic [TW-1:0]   cur_tag_c;
  logic [2:0]      inflight_c;
  logic [PW-1:0]   in_word_c;
  logic            out_free_c, take_skid_c, to_skid_c;

  assign pop_c    = out_valid & ready_in;
  assign x_last_c = (x_q == X_LAST);
  assign y_last_c = (y_q == Y_LAST);
  // Pixels already committed (stored or in flight) after this cycle's pop.
  assign inflight_c = 3'(out_valid) + 3'(skid_cnt) + 3'(mem_rd_en) + 3'(pend) - 3'(pop_c);
  assign cur_tag_c  = (state == IDLE) ? 4'b1010
                    : {(x_q == '0) && (y_q == '0), x_last_c && y_last_c, x_q == '0, x_last_c};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (issue_c) state_nxt = READ;
      READ:  if (issue_c && x_last_c)
               state_nxt = y_last_c ? DRAIN : ((LINE_GAP > 0) ? GAP : READ);
      GAP:   if (gap_q == GAP_LAST) state_nxt = READ;
      DRAIN: if (done_set_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_c    = 1'b0;
    done_set_c = 1'b0;
    case (state)
      IDLE:  issue_c    = start & ~done;
      READ:  issue_c    = (inflight_c <= 3'd2);
      DRAIN: done_set_c = pop_c & out_q[B_EOF];
      default: ;
    endcase
  end

  // Read address and raster counters
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      gap_q     <= '0;
      rd_tag    <= '0;
    end else begin
      mem_rd_en <= issue_c;
      gap_q     <= (state == GAP) ? gap_q + GW'(1) : '0;
      if (issue_c) begin
        rd_tag <= cur_tag_c;
        if (state == IDLE) begin
          mem_addr <= '0;
          x_q      <= XW'(1);
          y_q      <= '0;
        end else begin
          mem_addr <= mem_addr + ADDR_W'(1);
          if (x_last_c) begin
            x_q <= '0;
            y_q <= y_q + YW'(1);
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= done_set_c;
      if (state == IDLE && issue_c) busy <= 1'b1;
      else if (done_set_c)          busy <= 1'b0;
    end
  end

  assign in_word_c   = {pend_tag, mem_rdata};
  assign out_free_c  = ~out_valid | pop_c;
  assign take_skid_c = out_free_c && (skid_cnt != 2'd0);
  assign to_skid_c   = pend && !(out_free_c && (skid_cnt == 2'd0));

  // Output register backed by a 2-entry skid FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= 1'b0;
      pend_tag  <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      skid0     <= '0;
      skid1     <= '0;
      skid_cnt  <= '0;
    end else begin
      pend     <= mem_rd_en;
      pend_tag <= rd_tag;
      if (out_free_c) begin
        if (skid_cnt != 2'd0) begin
          out_q     <= skid0;
          out_valid <= 1'b1;
        end else if (pend) begin
          out_q     <= in_word_c;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      case ({take_skid_c, to_skid_c})
        2'b10: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b01: begin
          if (skid_cnt == 2'd0) skid0 <= in_word_c;
          else                  skid1 <= in_word_c;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= in_word_c;
          end else begin
            skid0 <= skid1;
            skid1 <= in_word_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign p_data = out_q[7:0];
  assign valid  = out_valid;
  assign sol    = out_q[B_SOL];
  assign eol    = out_q[B_EOL];
  assign sof    = out_q[B_SOF];
  assign eof    = out_q[B_EOF];

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: three geometries, directed and random
// backpressure, checked against a raster-order reference stream.
module tb_pixel_stream_source;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        reset_s [ND];
  logic        start_s [ND];
  logic        ready_s [ND];
  logic        rd_en_s [ND];
  logic [11:0] addr_s  [ND];
  logic [7:0]  rdata_s [ND];
  logic [7:0]  pdata_s [ND];
  logic        valid_s [ND];
  logic        sol_s   [ND];
  logic        eol_s   [ND];
  logic        sof_s   [ND];
  logic        eof_s   [ND];
  logic        busy_s  [ND];
  logic        done_s  [ND];
  logic [7:0]  mem [0:63];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pixel_stream_source #(.IMG_W(4), .IMG_H(2), .ADDR_W(12), .LINE_GAP(0)) u_d0 (
    .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .mem_rd_en(rd_en_s[0]),
    .mem_addr(addr_s[0]), .mem_rdata(rdata_s[0]), .p_data(pdata_s[0]), .valid(valid_s[0]),
    .ready_in(ready_s[0]), .sol(sol_s[0]), .eol(eol_s[0]), .sof(sof_s[0]), .eof(eof_s[0]),
    .busy(busy_s[0]), .done(done_s[0]));

  pixel_stream_source #(.IMG_W(4), .IMG_H(3), .ADDR_W(12), .LINE_GAP(3)) u_d1 (
    .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .mem_rd_en(rd_en_s[1]),
    .mem_addr(addr_s[1]), .mem_rdata(rdata_s[1]), .p_data(pdata_s[1]), .valid(valid_s[1]),
    .ready_in(ready_s[1]), .sol(sol_s[1]), .eol(eol_s[1]), .sof(sof_s[1]), .eof(eof_s[1]),
    .busy(busy_s[1]), .done(done_s[1]));

  pixel_stream_source #(.IMG_W(2), .IMG_H(1), .ADDR_W(12), .LINE_GAP(0)) u_d2 (
    .clk(clk), .reset(reset_s[2]), .start(start_s[2]), .mem_rd_en(rd_en_s[2]),
    .mem_addr(addr_s[2]), .mem_rdata(rdata_s[2]), .p_data(pdata_s[2]), .valid(valid_s[2]),
    .ready_in(ready_s[2]), .sol(sol_s[2]), .eol(eol_s[2]), .sof(sof_s[2]), .eof(eof_s[2]),
    .busy(busy_s[2]), .done(done_s[2]));

  // Synchronous frame memory, one-cycle read latency
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++)
      if (rd_en_s[d]) rdata_s[d] <= mem[addr_s[d][5:0]];
  end

  function automatic int w_of(input int d);
    return (d == 2) ? 2 : 4;
  endfunction
  function automatic int h_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 3 : 1);
  endfunction
  function automatic int g_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction
  function automatic logic [11:0] word_of(input int d);
    return {sof_s[d], eof_s[d], sol_s[d], eol_s[d], pdata_s[d]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entry: current cycle becomes the start cycle. Exit: in the done cycle.
  // mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: random ready.
  task automatic run_frame(input int d, input int mode, input bit poke);
    int w, h, g, n, k, got, issued, last_eol, last_acc, done_cyc;
    logic        prev_hold;
    logic [11:0] prev_w;
    logic [11:0] exp_q[$];
    w = w_of(d); h = h_of(d); g = g_of(d); n = w * h;
    k = 0; got = 0; issued = 0; last_eol = -1; last_acc = -1; done_cyc = -1;
    prev_hold = 1'b0; prev_w = '0;
    for (int i = 0; i < n; i++)
      exp_q.push_back({i == 0, i == n - 1, (i % w) == 0, (i % w) == w - 1, mem[i]});
    start_s[d] = 1'b1;
    ready_s[d] = 1'b1;
    while (done_cyc < 0 && k < 400) begin
      @(posedge clk); #1;
      k++;
      start_s[d] = poke && (k == 5);
      case (mode)
        0:       ready_s[d] = 1'b1;
        1:       ready_s[d] = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
        default: ready_s[d] = 1'($urandom_range(0, 1));
      endcase
      if (k == 1) begin
        check("busy_c1", 32'(busy_s[d]), 32'd1);
        check("rd_c1", 32'({rd_en_s[d], addr_s[d]}), 32'({1'b1, 12'd0}));
      end
      if (k == 2) check("valid_c2", 32'(valid_s[d]), 32'd0);
      if (k == 3) check("valid_c3", 32'(valid_s[d]), 32'd1);
      if (prev_hold) check("hold", 32'({valid_s[d], word_of(d)}), 32'({1'b1, prev_w}));
      if (rd_en_s[d]) begin
        issued++;
        check("rd_addr", 32'(addr_s[d]), 32'(issued - 1));
        check("credit", 32'(issued - got <= 3), 32'd1);
      end
      if (valid_s[d] && ready_s[d]) begin
        if (got < n) check("pix", 32'(word_of(d)), 32'(exp_q[got]));
        else         check("overrun", 32'(got), 32'(n - 1));
        if (mode == 0 && sol_s[d] && got > 0) check("gap", 32'(k - last_eol - 1), 32'(g));
        if (eol_s[d]) last_eol = k;
        last_acc = k;
        got++;
      end
      prev_hold = valid_s[d] && !ready_s[d];
      prev_w    = word_of(d);
      if (done_s[d]) done_cyc = k;
    end
    start_s[d] = 1'b0;
    check("timeout", 32'(done_cyc >= 0), 32'd1);
    check("count", 32'(got), 32'(n));
    check("done_lat", 32'(done_cyc), 32'(last_acc + 1));
    check("busy_done", 32'(busy_s[d]), 32'd0);
    if (mode == 0) check("done_cyc", 32'(done_cyc), 32'(3 + n + g * (h - 1)));
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      reset_s[d] = 1'b1; start_s[d] = 1'b0; ready_s[d] = 1'b1;
    end
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 10);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check("rst_state", 32'({valid_s[d], busy_s[d], done_s[d], rd_en_s[d], sol_s[d], eol_s[d],
                              sof_s[d], eof_s[d], addr_s[d], pdata_s[d]}), 32'd0);
      reset_s[d] = 1'b0;
    end
    @(posedge clk); #1;

    // Basic frame, then start in the done cycle is ignored
    run_frame(0, 0, 1'b0);
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    check("start_in_done", 32'({busy_s[0], rd_en_s[0], done_s[0]}), 32'd0);
    run_frame(0, 1, 1'b0);
    @(posedge clk); #1;
    run_frame(0, 0, 1'b1);
    @(posedge clk); #1;

    // Reset after three pixels, then a clean restart
    start_s[0] = 1'b1;
    ready_s[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      if (k >= 3) check("pre_rst_pix", 32'({valid_s[0], pdata_s[0]}), 32'({1'b1, 8'(k + 7)}));
      if (k == 6) reset_s[0] = 1'b1;
    end
    @(posedge clk); #1;
    reset_s[0] = 1'b0;
    check("post_rst", 32'({valid_s[0], busy_s[0], rd_en_s[0], done_s[0]}), 32'd0);
    run_frame(0, 0, 1'b0);

    @(posedge clk); #1;
    run_frame(1, 0, 1'b0);
    @(posedge clk); #1;
    run_frame(1, 1, 1'b0);
    @(posedge clk); #1;
    run_frame(2, 0, 1'b0);
    @(posedge clk); #1;
    run_frame(2, 2, 1'b0);

    // Random frame contents under random backpressure
    for (int r = 0; r < 9; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      run_frame(r % ND, 2, 1'(r % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
